// File: rtl/siso_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : siso_seq_ctrl
// Purpose  : Transfer sequencer for a DEPTH-stage serial-in serial-out chain.
//            A parallel word accepted on start is fed LSB-first into the
//            chain, the chain is then drained with zeros, and the bits
//            leaving the last stage are reassembled into a parallel word
//            that is presented on dout together with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      synchronous active-high reset
//   start    in   1      transfer request, sampled only while idle
//   din      in   WIDTH  word to transmit, latched on accepted start
//   abort    in   1      cancels a transfer that is shifting or draining
//   busy     out  1      high in SHIFT, DRAIN and DONE
//   done     out  1      one-cycle completion pulse (DONE state)
//   dout     out  WIDTH  reassembled word, held until the next done
//   ser_out  out  1      last chain stage
//   shift_en out  1      high while the chain advances (SHIFT, DRAIN)
// ============================================================================
module siso_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ser_out,
  output logic             shift_en
);

  // One spare count so the increment on the final drain edge never wraps.
  localparam int SW = $clog2(WIDTH + DEPTH + 1);

  localparam logic [SW-1:0] c_TX_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] c_S_LAST  = SW'(WIDTH + DEPTH - 1);
  localparam logic [SW-1:0] c_DEPTH   = SW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0] tx_q,    tx_d;
  logic [WIDTH-1:0] rx_q,    rx_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [SW-1:0]    s_q,     s_d;
  logic             w_feed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chain_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    s_d     = s_q;
    w_feed  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d    = din;
          s_d     = '0;
          rx_d    = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT, ST_DRAIN: begin
        if (abort) begin
          chain_d = '0;
          tx_d    = '0;
          rx_d    = '0;
          s_d     = '0;
          state_d = ST_IDLE;
        end else begin
          // While draining, zeros are pushed in so the chain ends up flushed.
          w_feed     = (state_q == ST_SHIFT) ? tx_q[0] : 1'b0;
          chain_d[0] = w_feed;
          for (int i = 1; i < DEPTH; i++) begin
            chain_d[i] = chain_q[i-1];
          end
          if (state_q == ST_SHIFT) begin
            tx_d = tx_q >> 1;
          end
          s_d = s_q + 1'b1;

          // Bit k of the word reaches the last stage after step k+DEPTH-1,
          // so it is picked up from ser_out on step k+DEPTH.
          if (s_q >= c_DEPTH) begin
            rx_d = {chain_q[DEPTH-1], rx_q[WIDTH-1:1]};
          end

          if ((state_q == ST_SHIFT) && (s_q == c_TX_LAST)) begin
            state_d = ST_DRAIN;
          end else if ((state_q == ST_DRAIN) && (s_q == c_S_LAST)) begin
            // Include the bit captured on this very edge.
            dout_d  = rx_d;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign shift_en = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign ser_out  = chain_q[DEPTH-1];
  assign dout     = dout_q;

endmodule
`default_nettype wire

// File: doc/siso_seq_ctrl.md
Name: siso_seq_ctrl

Overview:
Sequencer for a DEPTH-stage serial-in serial-out shift chain. It accepts a parallel WIDTH-bit word on a start strobe and feeds it LSB-first into an internal SISO chain. It drains the chain, reassembles the bits leaving the chain into a parallel word, and signals completion. It is the transfer controller placed in front of the team's SISO shift-register datapath, and doubles as a self-checking loopback engine.

Parameters:
WIDTH, 8, bits per transferred word (>=2)
DEPTH, 4, number of SISO flip-flop stages in the chain (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only when busy=0
din  input  WIDTH  word to send; latched on the accepted start edge
abort  input  1  synchronous cancel of an in-flight transfer
busy  output  1  high in SHIFT, DRAIN and DONE
done  output  1  one-cycle pulse; high only in DONE
dout  output  WIDTH  reassembled word; valid while done=1 and held until next done
ser_out  output  1  last chain stage (chain[DEPTH-1]), for observation
shift_en  output  1  high in SHIFT and DRAIN (chain advancing)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; chain, tx, rx and step counter cleared to 0.
  - dout=0, busy=0, done=0, ser_out=0, shift_en=0.
  - Reset wins over every other input, including mid-transfer. No done pulse follows a reset.
- States and transitions: IDLE, SHIFT, DRAIN, DONE.
  - IDLE: on start=1, tx<=din, step s<=0, rx<=0, go to SHIFT. start with busy=1 is ignored, with no queuing.
  - SHIFT: each edge chain[0]<=tx[0], tx<=tx>>1, chain[i]<=chain[i-1], s<=s+1. After the edge with s=WIDTH-1, go to DRAIN.
  - DRAIN: chain shifts as in SHIFT with 0 fed into chain[0], s<=s+1. After the edge with s=WIDTH+DEPTH-1, go to DONE and load dout from the final rx value, including the bit captured on that same edge.
  - DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- Capture rule: on every SHIFT/DRAIN edge with s>=DEPTH, rx<={ser_out, rx[WIDTH-1:1]} (LSB-first reassembly). Bit k of din leaves the chain and is captured at the edge with s=k+DEPTH.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+WIDTH+DEPTH, and busy falls after edge E0+WIDTH+DEPTH+1. The next start is accepted at the earliest at E0+WIDTH+DEPTH+2. Defaults give done 12 edges after acceptance.
- Counter: s is wide enough for WIDTH+DEPTH-1 without wrap. s holds its value in IDLE and DONE.
- abort=1 at an edge in SHIFT or DRAIN:
  - next state is IDLE; chain, tx, rx and s are cleared.
  - dout keeps its previous value and no done pulse is produced.
  - abort in IDLE or DONE has no effect, so a DONE pulse is never suppressed.
  - abort and start together in IDLE: start is accepted.
- Loopback property: every completed transfer gives dout==din of the accepted word.
- ser_out outside transfers is 0 after reset and after abort. After a normal completion the chain has been flushed with zeros, so it is also 0.

Test Plan:
- Reset: rst=1 for 3 edges with start=1, din=8'hFF -> busy=0, done=0, dout=8'h00, ser_out=0 throughout and one edge after rst falls (until start is re-sampled).
- Basic transfer: din=8'hA5, start pulse at E0 -> shift_en high E1..E12; ser_out shows 1,0,1,0,0,1,0,1 after edges E4..E11; done high only in the cycle after E12 with dout=8'hA5; busy low after E13.
- Back-to-back: start held high continuously with din=8'h3C then 8'hC3 changed mid-transfer -> the first word completes as 8'h3C; the second is accepted one edge after done, and its din is sampled only at that edge.
- Abort mid-transfer: din=8'hF0, abort pulse at E6 -> IDLE after E6, no done, dout retains the previous value, ser_out=0.
- Reset mid-DRAIN: rst=1 at E10 -> all outputs return to reset values at E10, no done ever appears, and a subsequent 8'h5A transfer completes correctly.
- Parameter sweep: WIDTH=2/DEPTH=1 and WIDTH=16/DEPTH=7 with words 2'b10 and 16'hBEEF -> done exactly WIDTH+DEPTH edges after acceptance, dout==din.
